// File: rtl/fft_frame_reader.sv
// fft_frame_reader: sink for the FFT result stream. It captures one frame of
// FRAME_LEN words into a local buffer and raises a completion interrupt. It then
// holds the stream off while software reads the buffer at random addresses.
// Software releases the buffer with a one-cycle pulse to arm the next capture.
//
// Stream handshake: a word moves only on a rising edge where i_data_valid and
// o_data_ready are both 1. The producer holds i_data stable while it waits.
// o_data_ready depends only on registered state, so it never depends
// combinationally on i_data_valid. When ready is low, words are stalled and
// never dropped.
module fft_frame_reader #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_frame_release,
  output logic              o_frame_ready,
  output logic              o_irq,
  output logic [ADDR_W:0]   o_wr_count,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   LEN_W    = (ADDR_W+1)'(FRAME_LEN);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic              hs;
  logic              last_hs;
  logic              release_hit;
  logic [DATA_W-1:0] mem [FRAME_LEN];

  assign o_data_ready = (state_q == FILL);
  assign hs           = i_data_valid & o_data_ready;
  assign last_hs      = hs && (wr_ptr == LAST_PTR);
  assign release_hit  = (state_q == FULL) && i_frame_release;
  assign o_state      = state_q;

  // State register; INIT exists only to give one quiet cycle after reset release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Next-state logic. A release is only meaningful once a frame is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = FILL;
      FILL:    if (last_hs) state_d = FULL;
      FULL:    if (i_frame_release) state_d = FILL;
      default: state_d = INIT;
    endcase
  end

  // Write pointer, word count, completion flag and interrupt pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr        <= '0;
      o_wr_count    <= '0;
      o_frame_ready <= 1'b0;
      o_irq         <= 1'b0;
    end else begin
      o_irq <= 1'b0;
      if (hs) begin
        o_wr_count <= o_wr_count + 1'b1;
        if (last_hs) begin
          wr_ptr        <= '0;
          o_frame_ready <= 1'b1;
          o_irq         <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (release_hit) begin
        o_frame_ready <= 1'b0;
        o_wr_count    <= '0;
      end
    end
  end

  // Frame buffer write port. Contents are not reset.
  always_ff @(posedge i_clk) begin
    if (hs) mem[wr_ptr] <= i_data;
  end

  // Registered read port. A read in the same cycle as a write returns the old word.
  // Out-of-range addresses return zero. The data holds between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        if ({1'b0, i_rd_addr} < LEN_W) o_rd_data <= mem[i_rd_addr];
        else                           o_rd_data <= '0;
      end
    end
  end

  // A FILL-to-FULL transition always coincides with a write.
  assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == FILL && state_d == FULL) |-> hs);

endmodule

// File: tb/tb_fft_frame_reader.sv
// Directed bench for fft_frame_reader with an 8-word frame.
module tb_fft_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [31:0] data;
  logic        data_ready;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        frame_release;
  logic        frame_ready;
  logic        irq;
  logic [3:0]  wr_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  fft_frame_reader #(.DATA_W(32), .FRAME_LEN(8), .ADDR_W(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_data_valid(data_valid), .i_data(data), .o_data_ready(data_ready),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_frame_release(frame_release), .o_frame_ready(frame_ready), .o_irq(irq),
    .o_wr_count(wr_count), .o_state(state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Advance one cycle. Inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b0; data = '0; rd_en = 1'b0; rd_addr = '0;
    frame_release = 1'b0;
    tick(); tick();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", data_ready); end
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rst_frame_ready: got %0b expected 0", frame_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b expected 0", irq); end
    checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL rst_wr_count: got %0d expected 0", wr_count); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd: got valid=%0b data=%0h expected 0/0", rd_valid, rd_data); end
    rst = 1'b0;
    tick();
    checks++; if (data_ready !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL rst_to_fill: got ready=%0b state=%0d expected 1/1", data_ready, state); end
  endtask

  // Continuous 0x100..0x107: one word per clock, irq one cycle after the last word.
  task automatic test_fill();
    data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 32'h100 + 32'(i);
      checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %0b expected 1", i, data_ready); end
      tick();
      checks++; if (wr_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, wr_count, i + 1); end
      checks++; if (irq !== (i == 7)) begin errors++; $display("FAIL fill_irq_%0d: got %0b expected %0b", i, irq, (i == 7)); end
    end
    checks++; if (frame_ready !== 1'b1 || data_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got frame_ready=%0b ready=%0b expected 1/0", frame_ready, data_ready); end
    data_valid = 1'b0;
    tick();
    checks++; if (irq !== 1'b0 || frame_ready !== 1'b1) begin errors++; $display("FAIL fill_irq_pulse: got irq=%0b frame_ready=%0b expected 0/1", irq, frame_ready); end
  endtask

  // Back-to-back reads, then a read in the same cycle as the release.
  task automatic test_read();
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr = 3'(i);
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h100 + 32'(i)) begin errors++; $display("FAIL read_%0d: got valid=%0b data=%0h expected 1/%0h", i, rd_valid, rd_data, 32'h100 + 32'(i)); end
    end
    rd_addr = 3'd2; frame_release = 1'b1;
    tick();
    checks++; if (rd_data !== 32'h102) begin errors++; $display("FAIL read_at_release: got %0h expected 102", rd_data); end
    checks++; if (data_ready !== 1'b1 || frame_ready !== 1'b0 || wr_count !== 4'd0) begin errors++; $display("FAIL release: got ready=%0b frame_ready=%0b count=%0d expected 1/0/0", data_ready, frame_ready, wr_count); end
    rd_en = 1'b0; frame_release = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h102) begin errors++; $display("FAIL read_hold: got valid=%0b data=%0h expected 0/102", rd_valid, rd_data); end
  endtask

  // Stall while FULL without loss, and read-during-write returns the old word.
  task automatic test_backpressure();
    data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 32'h180 + 32'(i);
      tick();
    end
    data = 32'h200;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (data_ready !== 1'b0 || wr_count !== 4'd8) begin errors++; $display("FAIL stall_%0d: got ready=%0b count=%0d expected 0/8", i, data_ready, wr_count); end
    end
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    checks++; if (data_ready !== 1'b1 || wr_count !== 4'd0) begin errors++; $display("FAIL stall_release: got ready=%0b count=%0d expected 1/0", data_ready, wr_count); end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 32'h200 + 32'(i); rd_addr = 3'(i);
      tick();
      checks++; if (rd_data !== 32'h180 + 32'(i)) begin errors++; $display("FAIL rd_wr_same_%0d: got %0h expected %0h", i, rd_data, 32'h180 + 32'(i)); end
    end
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      tick();
      checks++; if (rd_data !== 32'h200 + 32'(i)) begin errors++; $display("FAIL no_skip_%0d: got %0h expected %0h", i, rd_data, 32'h200 + 32'(i)); end
    end
    rd_en = 1'b0; frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  // Random valid gaps over three frames.
  task automatic test_random_gaps();
    int irq_seen = 0;
    int sent;
    int cyc;
    for (int f = 0; f < 3; f++) begin
      sent = 0; cyc = 0;
      while (sent < 8 && cyc < 200) begin
        data_valid = 1'($urandom_range(0, 1));
        data = 32'h400 + 32'(f * 16 + sent);
        tick(); cyc++;
        if (data_valid) sent++;
        if (irq) irq_seen++;
        checks++; if (wr_count !== 4'(sent)) begin errors++; $display("FAIL gap_count_f%0d: got %0d expected %0d", f, wr_count, sent); end
      end
      data_valid = 1'b0;
      checks++; if (sent != 8 || frame_ready !== 1'b1) begin errors++; $display("FAIL gap_frame_f%0d: got sent=%0d frame_ready=%0b expected 8/1", f, sent, frame_ready); end
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        rd_addr = 3'(i);
        tick();
        if (irq) irq_seen++;
        checks++; if (rd_data !== 32'h400 + 32'(f * 16 + i)) begin errors++; $display("FAIL gap_data_f%0d_%0d: got %0h expected %0h", f, i, rd_data, 32'h400 + 32'(f * 16 + i)); end
      end
      rd_en = 1'b0; frame_release = 1'b1;
      tick();
      frame_release = 1'b0;
      if (irq) irq_seen++;
    end
    checks++; if (irq_seen != 3) begin errors++; $display("FAIL gap_irq_count: got %0d expected 3", irq_seen); end
  endtask

  // Reset after five words discards the partial frame.
  task automatic test_reset_mid_frame();
    data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 32'h2f0 + 32'(i);
      tick();
    end
    rst = 1'b1;
    #1;
    checks++; if (data_ready !== 1'b0 || wr_count !== 4'd0 || irq !== 1'b0 || frame_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got ready=%0b count=%0d irq=%0b frame_ready=%0b expected 0/0/0/0", data_ready, wr_count, irq, frame_ready); end
    checks++; if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rd: got data=%0h valid=%0b expected 0/0", rd_data, rd_valid); end
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      data = 32'h300 + 32'(i);
      tick();
      checks++; if (irq !== (i == 7)) begin errors++; $display("FAIL mid_rst_irq_%0d: got %0b expected %0b", i, irq, (i == 7)); end
    end
    data_valid = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      tick();
      checks++; if (rd_data !== 32'h300 + 32'(i)) begin errors++; $display("FAIL mid_rst_data_%0d: got %0h expected %0h", i, rd_data, 32'h300 + 32'(i)); end
    end
    rd_en = 1'b0; frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  // A release pulse during FILL changes nothing.
  task automatic test_release_in_fill();
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 32'h500 + 32'(i);
      tick();
    end
    data_valid = 1'b0; frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    checks++; if (wr_count !== 4'd3 || data_ready !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL fill_release: got count=%0d ready=%0b state=%0d expected 3/1/1", wr_count, data_ready, state); end
    data_valid = 1'b1;
    for (int i = 3; i < 8; i++) begin
      data = 32'h500 + 32'(i);
      tick();
      checks++; if (irq !== (i == 7)) begin errors++; $display("FAIL fill_release_irq_%0d: got %0b expected %0b", i, irq, (i == 7)); end
    end
    data_valid = 1'b0; rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_data !== 32'h503) begin errors++; $display("FAIL fill_release_data: got %0h expected 503", rd_data); end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_fill();
    test_read();
    test_backpressure();
    test_random_gaps();
    test_reset_mid_frame();
    test_release_in_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
